md_arbiter: RTL and testbench

- Shares the single multiply/divide unit (HI/LO, 5-cycle mult, 10-cycle div) between two requesters.
  - Port 0: pipeline E stage.
  - Port 1: bridge/coprocessor side.
- Arbitrates requests and builds the R-type instruction word the unit decodes.
- Sequences issue, waits out busy, returns mfhi/mflo data and a done pulse to the owner.
- Forwards the exception request to the unit and cancels an unissued port-0 operation on flush.

---
 rtl/md_arbiter_if.sv | 56 +++++
 rtl/md_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_md_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_arbiter_if.sv
// Bundle of both requester ports plus the multiply/divide unit port of md_arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold *_req until *_gnt; the unit stalls via md_busy.
interface md_arbiter_if;
  // Port 0: pipeline E stage
  logic        p0_req;
  logic [2:0]  p0_op;
  logic [31:0] p0_a;
  logic [31:0] p0_b;
  logic        p0_gnt;
  logic        p0_done;
  logic        p0_abort;
  logic [31:0] p0_rdata;
  // Port 1: bridge / coprocessor side
  logic        p1_req;
  logic [2:0]  p1_op;
  logic [31:0] p1_a;
  logic [31:0] p1_b;
  logic        p1_gnt;
  logic        p1_done;
  logic [31:0] p1_rdata;
  // Exception request from CP0
  logic        flush;
  // Multiply/divide unit side
  logic        md_req;
  logic [31:0] md_instr;
  logic        md_start;
  logic [31:0] md_srcA;
  logic [31:0] md_srcB;
  logic        md_busy;
  logic [31:0] md_res;
  // Sticky watchdog error
  logic        err;

  // Arbiter view
  modport master (
    input  p0_req, p0_op, p0_a, p0_b,
    input  p1_req, p1_op, p1_a, p1_b,
    input  flush, md_busy, md_res,
    output p0_gnt, p0_done, p0_abort, p0_rdata,
    output p1_gnt, p1_done, p1_rdata,
    output md_req, md_instr, md_start, md_srcA, md_srcB,
    output err
  );

  // Environment view (requesters, CP0 and the unit)
  modport slave (
    output p0_req, p0_op, p0_a, p0_b,
    output p1_req, p1_op, p1_a, p1_b,
    output flush, md_busy, md_res,
    input  p0_gnt, p0_done, p0_abort, p0_rdata,
    input  p1_gnt, p1_done, p1_rdata,
    input  md_req, md_instr, md_start, md_srcA, md_srcB,
    input  err
  );
endinterface

// File: rtl/md_arbiter.sv
// Shares one HI/LO multiply/divide unit between two requesters and sequences issue/wait/done.
// Latency: gnt 1 cycle after IDLE sample; done at +2 (MT/MF), +8 (MULT), +13 (DIV) without stalls.
// Backpressure: one op in flight; requests wait in IDLE; unit busy/flush stretch WAIT.
// Optional: define MD_P0_PRIORITY_EN for fixed port-0 priority instead of round-robin.
module md_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  md_arbiter_if.master bus
);

  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state;
  logic        owner;      // 0 = port 0, 1 = port 1
  logic [2:0]  hold_op;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic        abort0;
  logic [31:0] rdata0, rdata1;
  logic [31:0] instr_q;
  logic        start_q;
  logic [31:0] src_a_q, src_b_q;
  logic        err_q;
  logic [WDW-1:0] wdog;

`ifdef MD_P0_PRIORITY_EN
`else
  logic        rr_last;    // port served most recently
`endif

  logic        any_req;
  logic        pick1;
  logic [2:0]  sel_op;
  logic [31:0] sel_a, sel_b;

  // R-type funct field the unit decodes for each op code
  function automatic logic [5:0] funct_of(input logic [2:0] op);
    logic [5:0] f;
    case (op)
      3'd0:    f = 6'h18;  // MULT
      3'd1:    f = 6'h19;  // MULTU
      3'd2:    f = 6'h1A;  // DIV
      3'd3:    f = 6'h1B;  // DIVU
      3'd4:    f = 6'h11;  // MTHI
      3'd5:    f = 6'h13;  // MTLO
      3'd6:    f = 6'h10;  // MFHI
      default: f = 6'h12;  // MFLO
    endcase
    return f;
  endfunction

  // Winner selection and operand mux for the IDLE sample
  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
`ifdef MD_P0_PRIORITY_EN
    pick1   = ~bus.p0_req;
`else
    // On a tie the port not served last wins
    pick1   = bus.p1_req & (~bus.p0_req | ~rr_last);
`endif
    sel_op  = pick1 ? bus.p1_op : bus.p0_op;
    sel_a   = pick1 ? bus.p1_a  : bus.p0_a;
    sel_b   = pick1 ? bus.p1_b  : bus.p0_b;
  end

  // Sequencer: arbitration, issue, busy wait with watchdog, completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      hold_op <= 3'd0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      abort0  <= 1'b0;
      rdata0  <= 32'd0;
      rdata1  <= 32'd0;
      instr_q <= 32'd0;
      start_q <= 1'b0;
      src_a_q <= 32'd0;
      src_b_q <= 32'd0;
      err_q   <= 1'b0;
      wdog    <= '0;
`ifdef MD_P0_PRIORITY_EN
`else
      rr_last <= 1'b1;
`endif
    end else begin
      // Pulses last a single cycle unless re-armed below
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      abort0 <= 1'b0;

      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner   <= pick1;
            hold_op <= sel_op;
            gnt0    <= ~pick1;
            gnt1    <= pick1;
            // Unit-facing bus is registered so it is stable for the whole ISSUE cycle
            instr_q <= {26'd0, funct_of(sel_op)};
            start_q <= ~sel_op[2];
            src_a_q <= sel_a;
            src_b_q <= sel_b;
            state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (bus.flush) begin
            // The unit ignores this cycle because md_req is high
            if (!owner) begin
              abort0  <= 1'b1;
              instr_q <= 32'd0;
              start_q <= 1'b0;
              state   <= S_IDLE;
            end
            // Port-1 ops are kept and simply reissued next cycle
          end else begin
            instr_q <= 32'd0;
            start_q <= 1'b0;
            if (!hold_op[2]) begin
              wdog  <= '0;
              state <= S_WAIT;
            end else begin
              if (hold_op[1]) begin
                // MFHI/MFLO: unit read data is valid during ISSUE
                if (owner) rdata1 <= bus.md_res;
                else       rdata0 <= bus.md_res;
              end
              done0 <= ~owner;
              done1 <= owner;
              state <= S_DONE;
            end
          end
        end

        S_WAIT: begin
          if (!bus.md_busy) begin
            done0 <= ~owner;
            done1 <= owner;
            state <= S_DONE;
          end else if (!bus.flush) begin
            // Flush freezes the unit, so frozen cycles are not counted
            if (wdog == WD_LAST) begin
              err_q <= 1'b1;
              done0 <= ~owner;
              done1 <= owner;
              state <= S_DONE;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
        end

        S_DONE: begin
`ifdef MD_P0_PRIORITY_EN
`else
          rr_last <= owner;
`endif
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.p0_gnt   = gnt0;
  assign bus.p0_done  = done0;
  assign bus.p0_abort = abort0;
  assign bus.p0_rdata = rdata0;
  assign bus.p1_gnt   = gnt1;
  assign bus.p1_done  = done1;
  assign bus.p1_rdata = rdata1;
  assign bus.md_req   = bus.flush;
  assign bus.md_instr = instr_q;
  assign bus.md_start = start_q;
  assign bus.md_srcA  = src_a_q;
  assign bus.md_srcB  = src_b_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_md_arbiter.sv
// Directed bench for md_arbiter with a behavioural HI/LO multiply/divide unit.
// Latency: checks done/gnt/abort cycle numbers counted from the IDLE sample cycle.
// Backpressure: requesters hold req until gnt; unit busy is modelled and can be forced.
module tb_md_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_arbiter_if bus();

  md_arbiter #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural multiply/divide unit ----------------
  logic [31:0] hi, lo, pend_hi, pend_lo;
  int          cnt;
  logic        force_busy;
  logic [5:0]  funct;
  assign funct = bus.md_instr[5:0];

  function automatic logic [63:0] md_calc(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    r  = 64'd0;
    case (f)
      6'h18: r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      6'h19: r = {32'd0, a} * {32'd0, b};
      6'h1A: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
      6'h1B: if (b != 0) r = {a % b, a / b};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cnt <= 0;
      hi  <= 32'd0;
      lo  <= 32'd0;
    end else if (!bus.md_req) begin
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
      if (bus.md_start) begin
        {pend_hi, pend_lo} <= md_calc(funct, bus.md_srcA, bus.md_srcB);
        cnt <= (funct[1]) ? 10 : 5;
      end else if (funct == 6'h11) begin
        hi <= bus.md_srcA;
      end else if (funct == 6'h13) begin
        lo <= bus.md_srcA;
      end
    end
  end

  assign bus.md_busy = (cnt != 0) | force_busy;
  assign bus.md_res  = (funct == 6'h10) ? hi : (funct == 6'h12) ? lo : 32'd0;

  // ---------------- helpers ----------------
  int          g_c, d_c, a_c;
  logic [31:0] ins_g, rd;
  logic        st_g;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one op from an IDLE cycle (cycle 0); flush is high for cycles [fl_from, fl_from+fl_len)
  task automatic do_op(input bit port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int fl_from, input int fl_len,
                       output int gnt_c, output int done_c, output int abort_c,
                       output logic [31:0] instr_g, output logic start_g, output logic [31:0] rdata);
    gnt_c = -1; done_c = -1; abort_c = -1; instr_g = 32'hDEAD; start_g = 1'bx; rdata = 32'hDEAD;
    if (!port) begin
      bus.p0_req = 1'b1; bus.p0_op = op; bus.p0_a = a; bus.p0_b = b;
    end else begin
      bus.p1_req = 1'b1; bus.p1_op = op; bus.p1_a = a; bus.p1_b = b;
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.flush = (cyc >= fl_from) && (cyc < fl_from + fl_len);
      step();
      if (port ? bus.p1_gnt : bus.p0_gnt) begin
        gnt_c = cyc + 1; instr_g = bus.md_instr; start_g = bus.md_start;
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
      end
      if (port ? bus.p1_done : bus.p0_done) begin
        done_c = cyc + 1; rdata = port ? bus.p1_rdata : bus.p0_rdata;
        break;
      end
      if (!port && bus.p0_abort) begin
        abort_c = cyc + 1;
        break;
      end
    end
    bus.flush = 1'b0; bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b%b exp=00", bus.p0_gnt, bus.p1_gnt); end
    checks++; if (bus.p0_done !== 1'b0 || bus.p1_done !== 1'b0 || bus.p0_abort !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b%b exp=000", bus.p0_done, bus.p1_done, bus.p0_abort); end
    checks++; if (bus.p0_rdata !== 32'd0 || bus.p1_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", bus.p0_rdata, bus.p1_rdata); end
    checks++; if (bus.md_instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.md_instr); end
    checks++; if (bus.md_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", bus.md_start); end
    checks++; if (bus.md_srcA !== 32'd0 || bus.md_srcB !== 32'd0) begin failures++; $display("FAIL reset_src got=%h/%h exp=0", bus.md_srcA, bus.md_srcB); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
  endtask

  task automatic test_mult_p0();
    do_op(1'b0, 3'd0, 32'hFFFFFFFF, 32'd2, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (g_c !== 1) begin failures++; $display("FAIL mult_gnt_cycle got=%0d exp=1", g_c); end
    checks++; if (ins_g !== 32'h18 || st_g !== 1'b1) begin failures++; $display("FAIL mult_issue got=%h/%b exp=18/1", ins_g, st_g); end
    checks++; if (d_c !== 8) begin failures++; $display("FAIL mult_done_cycle got=%0d exp=8", d_c); end
    do_op(1'b0, 3'd6, 32'd0, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (ins_g !== 32'h10 || st_g !== 1'b0) begin failures++; $display("FAIL mfhi_issue got=%h/%b exp=10/0", ins_g, st_g); end
    checks++; if (d_c !== 2) begin failures++; $display("FAIL mfhi_done_cycle got=%0d exp=2", d_c); end
    checks++; if (rd !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", rd); end
    do_op(1'b0, 3'd7, 32'd0, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (rd !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", rd); end
    checks++; if (bus.md_instr !== 32'd0 || bus.md_start !== 1'b0) begin failures++; $display("FAIL idle_instr got=%h/%b exp=0/0", bus.md_instr, bus.md_start); end
  endtask

  task automatic test_divu_p1();
    do_op(1'b1, 3'd3, 32'd100, 32'd7, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (ins_g !== 32'h1B) begin failures++; $display("FAIL divu_instr got=%h exp=1b", ins_g); end
    checks++; if (d_c !== 13) begin failures++; $display("FAIL divu_done_cycle got=%0d exp=13", d_c); end
    do_op(1'b1, 3'd6, 32'd0, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (rd !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=2", rd); end
    do_op(1'b1, 3'd7, 32'd0, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (rd !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=e", rd); end
  endtask

  task automatic test_abort();
    bit quiet;
    do_op(1'b0, 3'd5, 32'h0000ABCD, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (d_c !== 2) begin failures++; $display("FAIL mtlo_done_cycle got=%0d exp=2", d_c); end
    do_op(1'b0, 3'd2, 32'd50, 32'd5, 1, 1, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (a_c !== 2) begin failures++; $display("FAIL abort_cycle got=%0d exp=2", a_c); end
    checks++; if (d_c !== -1) begin failures++; $display("FAIL abort_no_done got=%0d exp=-1", d_c); end
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.md_busy !== 1'b0 || bus.p0_done !== 1'b0) quiet = 1'b0;
      step();
    end
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL abort_quiet got=%b exp=1", quiet); end
    do_op(1'b0, 3'd7, 32'd0, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (rd !== 32'h0000ABCD) begin failures++; $display("FAIL abort_prior_lo got=%h exp=abcd", rd); end
  endtask

  task automatic test_flush_wait();
    // Port-1 op survives flush in ISSUE and is reissued
    do_op(1'b1, 3'd4, 32'h00005A5A, 32'd0, 1, 2, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (d_c !== 4) begin failures++; $display("FAIL p1_reissue_done got=%0d exp=4", d_c); end
    do_op(1'b1, 3'd6, 32'd0, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (rd !== 32'h00005A5A) begin failures++; $display("FAIL p1_reissue_hi got=%h exp=5a5a", rd); end
    // Four frozen WAIT cycles push done from 8 to 12
    do_op(1'b1, 3'd1, 32'd3, 32'd5, 3, 4, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (d_c !== 12) begin failures++; $display("FAIL flush_wait_done got=%0d exp=12", d_c); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL flush_wait_err got=%b exp=0", bus.err); end
    do_op(1'b1, 3'd7, 32'd0, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (rd !== 32'd15) begin failures++; $display("FAIL multu_lo got=%h exp=f", rd); end
  endtask

  task automatic test_timeout();
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL timeout_pre_err got=%b exp=0", bus.err); end
    force_busy = 1'b1;
    do_op(1'b0, 3'd0, 32'd1, 32'd1, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    force_busy = 1'b0;
    checks++; if (d_c !== 18) begin failures++; $display("FAIL timeout_done got=%0d exp=18", d_c); end
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", bus.err); end
    do_op(1'b1, 3'd4, 32'd7, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus.err); end
    reset = 1'b1; step(); step(); reset = 1'b0;
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL err_reset got=%b exp=0", bus.err); end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    bus.p1_req = 1'b1; bus.p1_op = 3'd2; bus.p1_a = 32'd1000; bus.p1_b = 32'd3;
    step();
    bus.p1_req = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    checks++; if (bus.md_start !== 1'b0 || bus.md_instr !== 32'd0 || bus.p1_gnt !== 1'b0) begin failures++; $display("FAIL midreset_outs got=%b/%h/%b exp=0/0/0", bus.md_start, bus.md_instr, bus.p1_gnt); end
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.p1_done !== 1'b0 || bus.p0_abort !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL midreset_quiet got=%b exp=1", quiet); end
    do_op(1'b0, 3'd7, 32'd0, 32'd0, 99, 0, g_c, d_c, a_c, ins_g, st_g, rd);
    checks++; if (d_c !== 2) begin failures++; $display("FAIL midreset_next_op got=%0d exp=2", d_c); end
  endtask

  task automatic test_round_robin();
    int owners[$];
    int cycles[$];
    int exp_own[3];
    bit both;
`ifdef MD_P0_PRIORITY_EN
    exp_own = '{0, 0, 0};
`else
    exp_own = '{0, 1, 0};
`endif
    both = 1'b0;
    reset = 1'b1;
    bus.p0_req = 1'b1; bus.p0_op = 3'd5; bus.p0_a = 32'h11;
    bus.p1_req = 1'b1; bus.p1_op = 3'd5; bus.p1_a = 32'h22;
    step(); step();
    reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (bus.p0_gnt && bus.p1_gnt) both = 1'b1;
      if (bus.p0_gnt) begin owners.push_back(0); cycles.push_back(c); end
      if (bus.p1_gnt) begin owners.push_back(1); cycles.push_back(c); end
      if (c == 8) begin bus.p0_req = 1'b0; bus.p1_req = 1'b0; end
    end
    checks++; if (owners.size() !== 3 || both !== 1'b0) begin failures++; $display("FAIL rr_grant_count got=%0d/%b exp=3/0", owners.size(), both); end
    for (int k = 0; k < 3; k++) begin
      if (k < owners.size()) begin
        checks++; if (owners[k] !== exp_own[k] || cycles[k] !== 1 + 3 * k) begin failures++; $display("FAIL rr_grant%0d got=port%0d@%0d exp=port%0d@%0d", k, owners[k], cycles[k], exp_own[k], 1 + 3 * k); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; force_busy = 1'b0; bus.flush = 1'b0;
    bus.p0_req = 1'b0; bus.p0_op = 3'd0; bus.p0_a = 32'd0; bus.p0_b = 32'd0;
    bus.p1_req = 1'b0; bus.p1_op = 3'd0; bus.p1_a = 32'd0; bus.p1_b = 32'd0;
    step(); step(); step();
    reset = 1'b0;
    step();
    test_reset();
    test_mult_p0();
    test_divu_p1();
    test_abort();
    test_flush_wait();
    test_timeout();
    test_reset_mid();
    test_round_robin();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
